aes_core_arbiter: RTL

- Shares one AES-128 encryption core between two requesters (requester 0 and requester 1).
- Arbitrates round-robin and latches the winner's key and plaintext onto the core inputs.
- Pulses the core start, waits for the core's done, then returns the ciphertext with the requester ID over a valid/ready response channel.
- A watchdog ends any job whose core done never arrives and flags it as an error.

---
 rtl/aes_core_arbiter_if.sv | 51 +++++
 rtl/aes_core_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/aes_core_arbiter_if.sv
// Bundle of requester, AES core and response signals around the shared-core arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface aes_core_arbiter_if;
    logic         req0_valid;
    logic [127:0] req0_key;
    logic [127:0] req0_data;
    logic         req0_ready;

    logic         req1_valid;
    logic [127:0] req1_key;
    logic [127:0] req1_data;
    logic         req1_ready;

    logic         core_start;
    logic [127:0] core_key;
    logic [127:0] core_data;
    logic         core_done;
    logic [127:0] core_result;

    logic         rsp_valid;
    logic         rsp_id;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic         rsp_ready;

    logic         busy;

    modport slave (
        input  req0_valid, req0_key, req0_data,
        output req0_ready,
        input  req1_valid, req1_key, req1_data,
        output req1_ready,
        output core_start, core_key, core_data,
        input  core_done, core_result,
        output rsp_valid, rsp_id, rsp_data, rsp_error,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_key, req0_data,
        input  req0_ready,
        output req1_valid, req1_key, req1_data,
        input  req1_ready,
        input  core_start, core_key, core_data,
        output core_done, core_result,
        input  rsp_valid, rsp_id, rsp_data, rsp_error,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one AES-128 core between two requesters, with a
// watchdog that turns a missing core_done into an error response.
module aes_core_arbiter #(
    parameter int TIMEOUT = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    aes_core_arbiter_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WDOG_ONE  = TW'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic [TW-1:0] wdog;
    logic          grant0;
    logic          grant1;

    // Returns {grant1, grant0}; on contention the requester not served last wins.
    function automatic logic [1:0] pick_grant(input logic v0, input logic v1, input logic last);
        logic [1:0] g;
        g[0] = v0 & (~v1 | last);
        g[1] = v1 & (~v0 | ~last);
        return g;
    endfunction

    always_comb begin
        {grant1, grant0} = pick_grant(bus.req0_valid, bus.req1_valid, last_grant);
    end

    assign bus.req0_ready = (state == IDLE) & grant0;
    assign bus.req1_ready = (state == IDLE) & grant1;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            wdog           <= '0;
            bus.core_start <= 1'b0;
            bus.core_key   <= '0;
            bus.core_data  <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_error  <= 1'b0;
        end else begin
            bus.core_start <= 1'b0;
            case (state)
                IDLE: begin
                    // A grant already implies valid, so grant alone marks the accept edge.
                    if (grant0) begin
                        bus.core_key   <= bus.req0_key;
                        bus.core_data  <= bus.req0_data;
                        bus.rsp_id     <= 1'b0;
                        bus.core_start <= 1'b1;
                        state          <= LAUNCH;
                    end else if (grant1) begin
                        bus.core_key   <= bus.req1_key;
                        bus.core_data  <= bus.req1_data;
                        bus.rsp_id     <= 1'b1;
                        bus.core_start <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done is tested first so it beats a timeout landing in the same cycle
                    if (bus.core_done) begin
                        bus.rsp_data  <= bus.core_result;
                        bus.rsp_error <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (wdog == WDOG_LAST) begin
                        wdog          <= wdog + WDOG_ONE;
                        bus.rsp_data  <= '0;
                        bus.rsp_error <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wdog <= wdog + WDOG_ONE;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        last_grant    <= bus.rsp_id;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
